// File: rtl/ctrl_pipe_hazard_if.sv
// Control bundle between the main decoder / datapath and the pipeline hazard unit.
// The decoder side drives the D-stage fields; the hazard unit returns staged control and hazard selects.
interface ctrl_pipe_hazard_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
);
   logic             RegWriteD;
   logic [1:0]       ImmSrcD;
   logic             ALUSrcD;
   logic             MemWriteD;
   logic             MemReadD;
   logic [1:0]       ResultSrcD;
   logic             BranchD;
   logic [1:0]       ALUopD;
   logic             JumpD;
   logic             ValidD;
   logic [REG_W-1:0] rs1D;
   logic [REG_W-1:0] rs2D;
   logic [REG_W-1:0] rdD;
   logic             BranchTakenE;

   logic             ALUSrcE;
   logic [1:0]       ALUopE;
   logic [1:0]       ImmSrcE;
   logic             BranchE;
   logic             JumpE;
   logic             MemWriteM;
   logic             MemReadM;
   logic             RegWriteW;
   logic [1:0]       ResultSrcW;
   logic [REG_W-1:0] rdW;
   logic             PCSrcE;
   logic             StallF;
   logic             StallD;
   logic             FlushD;
   logic             FlushE;
   logic [1:0]       ForwardAE;
   logic [1:0]       ForwardBE;
   logic [CNT_W-1:0] InstRet;

   modport master (
      output RegWriteD, ImmSrcD, ALUSrcD, MemWriteD, MemReadD, ResultSrcD,
             BranchD, ALUopD, JumpD, ValidD, rs1D, rs2D, rdD, BranchTakenE,
      input  ALUSrcE, ALUopE, ImmSrcE, BranchE, JumpE, MemWriteM, MemReadM,
             RegWriteW, ResultSrcW, rdW, PCSrcE, StallF, StallD, FlushD, FlushE,
             ForwardAE, ForwardBE, InstRet
   );

   modport slave (
      input  RegWriteD, ImmSrcD, ALUSrcD, MemWriteD, MemReadD, ResultSrcD,
             BranchD, ALUopD, JumpD, ValidD, rs1D, rs2D, rdD, BranchTakenE,
      output ALUSrcE, ALUopE, ImmSrcE, BranchE, JumpE, MemWriteM, MemReadM,
             RegWriteW, ResultSrcW, rdW, PCSrcE, StallF, StallD, FlushD, FlushE,
             ForwardAE, ForwardBE, InstRet
   );
endinterface

// File: rtl/ctrl_pipe_hazard.sv
// Carries decoded control through ID/EX, EX/MEM, MEM/WB of the RV32I pipeline and
// generates load-use stall, redirect flush, EX operand forwarding and the retire count.
module ctrl_pipe_hazard #(
   parameter int REG_W = 5,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   ctrl_pipe_hazard_if.slave  bus
);

   typedef struct packed {
      logic             reg_write;
      logic [1:0]       imm_src;
      logic             alu_src;
      logic             mem_write;
      logic             mem_read;
      logic [1:0]       result_src;
      logic             branch;
      logic [1:0]       alu_op;
      logic             jump;
      logic             valid;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
   } ex_t;

   typedef struct packed {
      logic             reg_write;
      logic             mem_write;
      logic             mem_read;
      logic [1:0]       result_src;
      logic [REG_W-1:0] rd;
      logic             valid;
   } mem_t;

   typedef struct packed {
      logic             reg_write;
      logic [1:0]       result_src;
      logic [REG_W-1:0] rd;
      logic             valid;
   } wb_t;

   ex_t              ex_q,  ex_d;
   mem_t             mem_q, mem_d;
   wb_t              wb_q,  wb_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             pc_src;
   logic             lw_stall;
   logic             flush_e;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] rs,
      input mem_t             m,
      input wb_t              w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (m.reg_write && (m.rd != '0) && (m.rd == rs))
         sel = 2'b10;
      else if (w.reg_write && (w.rd != '0) && (w.rd == rs))
         sel = 2'b01;
      return sel;
   endfunction

   // A redirect squashes the D instruction, so it must not also raise a stall.
   always_comb begin
      pc_src   = (ex_q.branch & bus.BranchTakenE) | ex_q.jump;
      lw_stall = ex_q.mem_read
               & (ex_q.rd != '0)
               & ((ex_q.rd == bus.rs1D) | (ex_q.rd == bus.rs2D))
               & bus.ValidD
               & ~pc_src;
      flush_e  = pc_src | lw_stall;
      fwd_a    = fwd_sel(ex_q.rs1, mem_q, wb_q);
      fwd_b    = fwd_sel(ex_q.rs2, mem_q, wb_q);
   end

   // Empty D slots enter E as full bubbles so stray control bits have no side effects.
   always_comb begin
      ex_d = '0;
      if (!flush_e && bus.ValidD) begin
         ex_d.reg_write  = bus.RegWriteD;
         ex_d.imm_src    = bus.ImmSrcD;
         ex_d.alu_src    = bus.ALUSrcD;
         ex_d.mem_write  = bus.MemWriteD;
         ex_d.mem_read   = bus.MemReadD;
         ex_d.result_src = bus.ResultSrcD;
         ex_d.branch     = bus.BranchD;
         ex_d.alu_op     = bus.ALUopD;
         ex_d.jump       = bus.JumpD;
         ex_d.valid      = 1'b1;
         ex_d.rs1        = bus.rs1D;
         ex_d.rs2        = bus.rs2D;
         ex_d.rd         = bus.rdD;
      end
   end

   always_comb begin
      mem_d            = '0;
      mem_d.reg_write  = ex_q.reg_write;
      mem_d.mem_write  = ex_q.mem_write;
      mem_d.mem_read   = ex_q.mem_read;
      mem_d.result_src = ex_q.result_src;
      mem_d.rd         = ex_q.rd;
      mem_d.valid      = ex_q.valid;

      wb_d             = '0;
      wb_d.reg_write   = mem_q.reg_write;
      wb_d.result_src  = mem_q.result_src;
      wb_d.rd          = mem_q.rd;
      wb_d.valid       = mem_q.valid;

      cnt_d            = cnt_q + CNT_W'(wb_q.valid);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.ALUSrcE    = ex_q.alu_src;
   assign bus.ALUopE     = ex_q.alu_op;
   assign bus.ImmSrcE    = ex_q.imm_src;
   assign bus.BranchE    = ex_q.branch;
   assign bus.JumpE      = ex_q.jump;
   assign bus.MemWriteM  = mem_q.mem_write;
   assign bus.MemReadM   = mem_q.mem_read;
   assign bus.RegWriteW  = wb_q.reg_write;
   assign bus.ResultSrcW = wb_q.result_src;
   assign bus.rdW        = wb_q.rd;
   assign bus.PCSrcE     = pc_src;
   assign bus.StallF     = lw_stall;
   assign bus.StallD     = lw_stall;
   assign bus.FlushD     = pc_src;
   assign bus.FlushE     = flush_e;
   assign bus.ForwardAE  = fwd_a;
   assign bus.ForwardBE  = fwd_b;
   assign bus.InstRet    = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Self-checking bench for ctrl_pipe_hazard: directed scenarios plus a random
// instruction stream compared against a slot-level pipeline model.
module tb_ctrl_pipe_hazard;
   localparam int REG_W = 5;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ctrl_pipe_hazard_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
   ctrl_pipe_hazard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic       rw;
      logic [1:0] imm;
      logic       alusrc;
      logic       mw;
      logic       mr;
      logic [1:0] rs;
      logic       br;
      logic [1:0] aluop;
      logic       jmp;
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } instr_t;

   int checks = 0;
   int errors = 0;

   // model: instruction records occupying E, M, W plus the retire count
   instr_t      m_e = '0, m_m = '0, m_w = '0;
   logic [31:0] m_cnt = '0;
   instr_t      cur_d = '0;
   logic        cur_tk = 1'b0;
   instr_t      idle = '0;

   function automatic instr_t ins(input logic rw, input logic [1:0] rs, input logic mr,
                                  input logic mw, input logic br, input logic jmp,
                                  input logic [1:0] aluop, input logic alusrc,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd);
      instr_t r;
      r = '0;
      r.rw = rw; r.rs = rs; r.mr = mr; r.mw = mw; r.br = br; r.jmp = jmp;
      r.aluop = aluop; r.alusrc = alusrc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
      r.v = 1'b1;
      return r;
   endfunction

   function automatic instr_t f_add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
      return ins(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, a, b, rd);
   endfunction
   function automatic instr_t f_lw(input logic [4:0] rd, input logic [4:0] a);
      return ins(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, a, 5'd0, rd);
   endfunction
   function automatic instr_t f_beq(input logic [4:0] a, input logic [4:0] b);
      return ins(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, a, b, 5'd0);
   endfunction

   function automatic instr_t rnd_instr();
      instr_t r;
      r.rw     = 1'($urandom);
      r.imm    = 2'($urandom);
      r.alusrc = 1'($urandom);
      r.mw     = ($urandom_range(0, 5) == 0);
      r.mr     = ($urandom_range(0, 2) == 0);
      r.rs     = 2'($urandom);
      r.br     = ($urandom_range(0, 4) == 0);
      r.aluop  = 2'($urandom);
      r.jmp    = ($urandom_range(0, 9) == 0);
      r.v      = ($urandom_range(0, 7) != 0);
      r.rs1    = 5'($urandom_range(0, 3));
      r.rs2    = 5'($urandom_range(0, 3));
      r.rd     = 5'($urandom_range(0, 3));
      return r;
   endfunction

   function automatic logic m_pcsrc();
      return (m_e.br & cur_tk) | m_e.jmp;
   endfunction

   function automatic logic m_lw();
      return m_e.mr && (m_e.rd != 0) && ((m_e.rd == cur_d.rs1) || (m_e.rd == cur_d.rs2))
             && cur_d.v && !m_pcsrc();
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (m_m.rw && m_m.rd != 0 && m_m.rd == rs) return 2'b10;
      if (m_w.rw && m_w.rd != 0 && m_w.rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic drive(input instr_t i, input logic tk);
      bus.RegWriteD    = i.rw;
      bus.ImmSrcD      = i.imm;
      bus.ALUSrcD      = i.alusrc;
      bus.MemWriteD    = i.mw;
      bus.MemReadD     = i.mr;
      bus.ResultSrcD   = i.rs;
      bus.BranchD      = i.br;
      bus.ALUopD       = i.aluop;
      bus.JumpD        = i.jmp;
      bus.ValidD       = i.v;
      bus.rs1D         = i.rs1;
      bus.rs2D         = i.rs2;
      bus.rdD          = i.rd;
      bus.BranchTakenE = tk;
      cur_d  = i;
      cur_tk = tk;
      #3;
   endtask

   task automatic adv();
      logic pc, lw;
      pc = m_pcsrc();
      lw = m_lw();
      @(posedge clk);
      if (rst) begin
         m_cnt = m_cnt + 32'(m_w.v);
         m_w   = m_m;
         m_m   = m_e;
         m_e   = (pc || lw || !cur_d.v) ? instr_t'('0) : cur_d;
      end
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         drive(idle, 1'b0);
         adv();
      end
   endtask

   task automatic test_reset();
      logic [27:0] outs;
      drive(idle, 1'b0);
      outs = {bus.ALUSrcE, bus.ALUopE, bus.ImmSrcE, bus.BranchE, bus.JumpE, bus.MemWriteM,
              bus.MemReadM, bus.RegWriteW, bus.ResultSrcW, bus.rdW, bus.PCSrcE, bus.StallF,
              bus.StallD, bus.FlushD, bus.FlushE, bus.ForwardAE, bus.ForwardBE};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      checks++;
      if (bus.InstRet !== 32'd0) begin
         errors++;
         $display("FAIL reset_instret: got %0d expected 0", bus.InstRet);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(idle, 1'b0);
      checks++;
      if ({bus.RegWriteW, bus.PCSrcE, bus.FlushE, bus.InstRet} !== '0) begin
         errors++;
         $display("FAIL reset_release: got %h expected 0",
                  {bus.RegWriteW, bus.PCSrcE, bus.FlushE, bus.InstRet});
      end
      adv();
   endtask

   task automatic test_retire();
      drive(f_add(5'd3, 5'd1, 5'd2), 1'b0);
      adv();
      for (int k = 1; k <= 2; k++) begin
         drive(idle, 1'b0);
         checks++;
         if (bus.RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL retire_early cycle %0d: RegWriteW got %b expected 0", k, bus.RegWriteW);
         end
         adv();
      end
      drive(idle, 1'b0);
      checks++;
      if ({bus.RegWriteW, bus.rdW, bus.ResultSrcW} !== {1'b1, 5'd3, 2'b00}) begin
         errors++;
         $display("FAIL retire_wb: got rw=%b rd=%0d rs=%b expected rw=1 rd=3 rs=00",
                  bus.RegWriteW, bus.rdW, bus.ResultSrcW);
      end
      checks++;
      if (bus.InstRet !== 32'd0) begin
         errors++;
         $display("FAIL retire_cnt_before: got %0d expected 0", bus.InstRet);
      end
      adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.InstRet, bus.RegWriteW} !== {32'd1, 1'b0}) begin
         errors++;
         $display("FAIL retire_cnt_after: got cnt=%0d rw=%b expected cnt=1 rw=0",
                  bus.InstRet, bus.RegWriteW);
      end
      adv();
      idle_cycles(2);
   endtask

   task automatic test_load_use();
      drive(f_lw(5'd5, 5'd2), 1'b0);
      adv();
      drive(f_add(5'd6, 5'd5, 5'd1), 1'b0);
      checks++;
      if ({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD} !== 4'b1110) begin
         errors++;
         $display("FAIL load_use_stall: got F/D/FE/FD=%b expected 1110",
                  {bus.StallF, bus.StallD, bus.FlushE, bus.FlushD});
      end
      adv();
      drive(f_add(5'd6, 5'd5, 5'd1), 1'b0);
      checks++;
      if ({bus.StallF, bus.StallD, bus.FlushE} !== 3'b000) begin
         errors++;
         $display("FAIL load_use_release: got %b expected 000",
                  {bus.StallF, bus.StallD, bus.FlushE});
      end
      adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0100) begin
         errors++;
         $display("FAIL load_use_fwd: got A=%b B=%b expected A=01 B=00",
                  bus.ForwardAE, bus.ForwardBE);
      end
      adv();
      idle_cycles(4);
   endtask

   task automatic test_forward();
      drive(f_add(5'd4, 5'd1, 5'd2), 1'b0); adv();
      drive(f_add(5'd7, 5'd4, 5'd4), 1'b0); adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== 4'b1010) begin
         errors++;
         $display("FAIL fwd_mem: got A=%b B=%b expected 10/10", bus.ForwardAE, bus.ForwardBE);
      end
      adv();
      idle_cycles(4);
      drive(f_add(5'd4, 5'd1, 5'd2), 1'b0); adv();
      drive(f_add(5'd9, 5'd0, 5'd1), 1'b0); adv();
      drive(f_add(5'd7, 5'd4, 5'd4), 1'b0); adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0101) begin
         errors++;
         $display("FAIL fwd_wb: got A=%b B=%b expected 01/01", bus.ForwardAE, bus.ForwardBE);
      end
      adv();
      idle_cycles(4);
      // two producers of x4 in flight: the younger one in MEM must win
      drive(f_add(5'd4, 5'd1, 5'd2), 1'b0); adv();
      drive(f_add(5'd4, 5'd3, 5'd2), 1'b0); adv();
      drive(f_add(5'd7, 5'd4, 5'd2), 1'b0); adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== 4'b1000) begin
         errors++;
         $display("FAIL fwd_priority: got A=%b B=%b expected 10/00", bus.ForwardAE, bus.ForwardBE);
      end
      adv();
      idle_cycles(4);
   endtask

   task automatic test_redirect();
      logic [31:0] start;
      instr_t      x;
      start = m_cnt;
      drive(f_beq(5'd1, 5'd2), 1'b0); adv();
      drive(f_lw(5'd5, 5'd2), 1'b1);
      checks++;
      if ({bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF, bus.StallD} !== 5'b11100) begin
         errors++;
         $display("FAIL redirect_taken: got %b expected 11100",
                  {bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF, bus.StallD});
      end
      adv();
      drive(idle, 1'b0); adv();
      idle_cycles(4);
      // load-flavoured branch in E makes a load-use and a redirect coincide
      x = ins(1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 5'd2, 5'd0, 5'd5);
      drive(x, 1'b0); adv();
      drive(f_add(5'd6, 5'd5, 5'd1), 1'b0);
      checks++;
      if ({bus.PCSrcE, bus.StallF, bus.FlushE} !== 3'b011) begin
         errors++;
         $display("FAIL redirect_not_taken_stall: got %b expected 011",
                  {bus.PCSrcE, bus.StallF, bus.FlushE});
      end
      drive(f_add(5'd6, 5'd5, 5'd1), 1'b1);
      checks++;
      if ({bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF, bus.StallD} !== 5'b11100) begin
         errors++;
         $display("FAIL redirect_beats_stall: got %b expected 11100",
                  {bus.PCSrcE, bus.FlushD, bus.FlushE, bus.StallF, bus.StallD});
      end
      adv();
      drive(idle, 1'b0); adv();
      idle_cycles(4);
      drive(idle, 1'b0);
      checks++;
      if (bus.InstRet !== start + 32'd2) begin
         errors++;
         $display("FAIL redirect_retire: got %0d expected %0d", bus.InstRet, start + 32'd2);
      end
      adv();
   endtask

   task automatic test_x0();
      drive(f_add(5'd0, 5'd1, 5'd2), 1'b0); adv();
      drive(f_add(5'd8, 5'd0, 5'd0), 1'b0); adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.ForwardAE, bus.ForwardBE} !== 4'b0000) begin
         errors++;
         $display("FAIL x0_no_fwd_mem: got A=%b B=%b expected 00/00", bus.ForwardAE, bus.ForwardBE);
      end
      adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.RegWriteW, bus.rdW, bus.ForwardAE} !== {1'b1, 5'd0, 2'b00}) begin
         errors++;
         $display("FAIL x0_wb: got rw=%b rd=%0d A=%b expected rw=1 rd=0 A=00",
                  bus.RegWriteW, bus.rdW, bus.ForwardAE);
      end
      adv();
      idle_cycles(4);
   endtask

   task automatic test_reset_midstream();
      logic [59:0] outs;
      drive(f_add(5'd1, 5'd2, 5'd3), 1'b0); adv();
      drive(f_lw(5'd2, 5'd1), 1'b0); adv();
      drive(ins(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 5'd0, 5'd0, 5'd1), 1'b0); adv();
      drive(idle, 1'b0);
      checks++;
      if ({bus.PCSrcE, bus.MemReadM, bus.RegWriteW} !== 3'b111) begin
         errors++;
         $display("FAIL midrst_inflight: got %b expected 111",
                  {bus.PCSrcE, bus.MemReadM, bus.RegWriteW});
      end
      rst = 1'b0;
      #1;
      outs = {bus.ALUSrcE, bus.ALUopE, bus.ImmSrcE, bus.BranchE, bus.JumpE, bus.MemWriteM,
              bus.MemReadM, bus.RegWriteW, bus.ResultSrcW, bus.rdW, bus.PCSrcE, bus.StallF,
              bus.StallD, bus.FlushD, bus.FlushE, bus.ForwardAE, bus.ForwardBE, bus.InstRet};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL midrst_async_clear: got %h expected 0", outs);
      end
      m_e = '0; m_m = '0; m_w = '0; m_cnt = '0;
      adv();
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         drive(idle, 1'b0);
         checks++;
         if ({bus.InstRet, bus.RegWriteW, bus.MemReadM} !== {32'd0, 2'b00}) begin
            errors++;
            $display("FAIL midrst_no_retire cycle %0d: got cnt=%0d rw=%b mr=%b expected 0",
                     k, bus.InstRet, bus.RegWriteW, bus.MemReadM);
         end
         adv();
      end
   endtask

   task automatic test_random();
      instr_t d;
      logic   stall_prev, flush_prev;
      logic [7:0]  exp_e, act_e;
      logic [9:0]  exp_mw, act_mw;
      logic [8:0]  exp_hz, act_hz;
      stall_prev = 1'b0;
      flush_prev = 1'b0;
      d = idle;
      for (int c = 0; c < 400; c++) begin
         if (stall_prev) begin
            d = cur_d;
         end else if (flush_prev) begin
            d = rnd_instr();
            d.v = 1'b0;
         end else begin
            d = rnd_instr();
         end
         drive(d, 1'($urandom));
         exp_e  = {m_e.alusrc, m_e.aluop, m_e.imm, m_e.br, m_e.jmp, 1'b0};
         act_e  = {bus.ALUSrcE, bus.ALUopE, bus.ImmSrcE, bus.BranchE, bus.JumpE, 1'b0};
         exp_mw = {m_m.mw, m_m.mr, m_w.rw, m_w.rs, m_w.rd};
         act_mw = {bus.MemWriteM, bus.MemReadM, bus.RegWriteW, bus.ResultSrcW, bus.rdW};
         exp_hz = {m_pcsrc(), m_lw(), m_lw(), m_pcsrc(), m_pcsrc() | m_lw(),
                   m_fwd(m_e.rs1), m_fwd(m_e.rs2)};
         act_hz = {bus.PCSrcE, bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
                   bus.ForwardAE, bus.ForwardBE};
         checks++;
         if (act_e !== exp_e) begin
            errors++;
            $display("FAIL rnd_ex cycle %0d: got %b expected %b", c, act_e, exp_e);
         end
         checks++;
         if (act_mw !== exp_mw) begin
            errors++;
            $display("FAIL rnd_mem_wb cycle %0d: got %b expected %b", c, act_mw, exp_mw);
         end
         checks++;
         if (act_hz !== exp_hz) begin
            errors++;
            $display("FAIL rnd_hazard cycle %0d: got %b expected %b", c, act_hz, exp_hz);
         end
         checks++;
         if (bus.InstRet !== m_cnt) begin
            errors++;
            $display("FAIL rnd_instret cycle %0d: got %0d expected %0d", c, bus.InstRet, m_cnt);
         end
         stall_prev = m_lw();
         flush_prev = m_pcsrc();
         adv();
      end
   endtask

   initial begin
      test_reset();
      test_retire();
      test_load_use();
      test_forward();
      test_redirect();
      test_x0();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
